// File: rtl/assoc_recall_if.sv
// assoc_recall_if: recall request/result handshake plus connection-memory read port
interface assoc_recall_if #(
  parameter int NUM_CLASSES = 16,
  parameter int CLASS_W = $clog2(NUM_CLASSES),
  parameter int WEIGHT_W = 16
);
  logic recall_start;
  logic [CLASS_W:0] key_class;
  logic recall_busy;
  logic recall_done;
  logic recall_found;
  logic [CLASS_W-1:0] response_class;
  logic [WEIGHT_W-1:0] response_weight;
  logic conn_rd_en;
  logic [CLASS_W-1:0] conn_rd_key;
  logic [CLASS_W-1:0] conn_rd_resp;
  logic conn_rd_presence;
  logic [WEIGHT_W-1:0] conn_rd_weight;
  modport master (
    output recall_start, key_class, conn_rd_presence, conn_rd_weight,
    input recall_busy, recall_done, recall_found, response_class, response_weight,
    input conn_rd_en, conn_rd_key, conn_rd_resp
  );
  modport slave (
    input recall_start, key_class, conn_rd_presence, conn_rd_weight,
    output recall_busy, recall_done, recall_found, response_class, response_weight,
    output conn_rd_en, conn_rd_key, conn_rd_resp
  );
endinterface

// File: rtl/assoc_recall.sv
// assoc_recall: scans a key's connection row and returns the strongest present response class
module assoc_recall #(
  parameter int NUM_CLASSES = 16,
  parameter int CLASS_W = $clog2(NUM_CLASSES),
  parameter int WEIGHT_W = 16
) (
  input logic clk,
  input logic rst,
  assoc_recall_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  localparam logic [CLASS_W:0] LAST = (CLASS_W+1)'(NUM_CLASSES);
  state_t state;
  logic [CLASS_W:0] cnt;
  logic rd_q;
  logic [CLASS_W-1:0] resp_q;
  logic found;
  logic [CLASS_W-1:0] cls;
  logic [WEIGHT_W-1:0] best;
  logic take;
  // rd_q marks the cycle in which the memory returns data for column resp_q
  always_comb take = rd_q && bus.conn_rd_presence && (!found || bus.conn_rd_weight > best);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rd_q <= 1'b0;
      resp_q <= '0;
      found <= 1'b0;
      cls <= '0;
      best <= '0;
      bus.recall_busy <= 1'b0;
      bus.recall_done <= 1'b0;
      bus.recall_found <= 1'b0;
      bus.response_class <= '0;
      bus.response_weight <= '0;
      bus.conn_rd_en <= 1'b0;
      bus.conn_rd_key <= '0;
      bus.conn_rd_resp <= '0;
    end else begin
      rd_q <= bus.conn_rd_en;
      resp_q <= bus.conn_rd_resp;
      if (take) begin
        found <= 1'b1;
        cls <= resp_q;
        best <= bus.conn_rd_weight;
      end
      case (state)
        IDLE: if (bus.recall_start) begin
          found <= 1'b0;
          cls <= '0;
          best <= '0;
          bus.recall_busy <= 1'b1;
          if (bus.key_class < LAST) begin
            state <= SCAN;
            bus.conn_rd_key <= bus.key_class[CLASS_W-1:0];
            bus.conn_rd_en <= 1'b1;
            bus.conn_rd_resp <= '0;
            cnt <= {{CLASS_W{1'b0}}, 1'b1};
          end else begin
            state <= DONE;
            bus.recall_done <= 1'b1;
            bus.recall_found <= 1'b0;
            bus.response_class <= '0;
            bus.response_weight <= '0;
          end
        end
        SCAN: if (cnt == LAST) begin
          bus.conn_rd_en <= 1'b0;
          state <= DRAIN;
        end else begin
          bus.conn_rd_resp <= cnt[CLASS_W-1:0];
          cnt <= cnt + 1'b1;
        end
        DRAIN: begin
          state <= DONE;
          bus.recall_done <= 1'b1;
          bus.recall_found <= found || take;
          bus.response_class <= take ? resp_q : cls;
          bus.response_weight <= take ? bus.conn_rd_weight : best;
        end
        DONE: begin
          state <= IDLE;
          bus.recall_done <= 1'b0;
          bus.recall_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_assoc_recall.sv
// tb_assoc_recall: randomized and directed checks of assoc_recall against a row-maximum reference model
module tb_assoc_recall;
  logic clk;
  logic rst;
  int vectors;
  int miscompares;
  logic pres [16][16];
  logic [15:0] wt [16][16];
  assoc_recall_if #(.NUM_CLASSES(16), .CLASS_W(4), .WEIGHT_W(16)) bus ();
  assoc_recall #(.NUM_CLASSES(16), .CLASS_W(4), .WEIGHT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end
  // connection memory: one-cycle read latency, garbage when not strobed
  always @(posedge clk) begin
    if (bus.conn_rd_en) begin
      bus.conn_rd_presence <= pres[bus.conn_rd_key][bus.conn_rd_resp];
      bus.conn_rd_weight <= wt[bus.conn_rd_key][bus.conn_rd_resp];
    end else begin
      bus.conn_rd_presence <= 1'($urandom);
      bus.conn_rd_weight <= 16'($urandom);
    end
  end
  // winner = largest present weight, lowest column among equals
  function automatic void model(input logic [4:0] k, output logic f, output logic [3:0] c, output logic [15:0] w);
    f = 1'b0;
    c = '0;
    w = '0;
    if (k < 5'd16) begin
      for (int i = 0; i < 16; i++)
        if (pres[k[3:0]][i]) begin
          f = 1'b1;
          if (wt[k[3:0]][i] > w) w = wt[k[3:0]][i];
        end
      for (int i = 15; i >= 0; i--)
        if (pres[k[3:0]][i] && wt[k[3:0]][i] == w) c = i[3:0];
    end
  endfunction
  task automatic clear_mem;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        pres[i][j] = 1'b0;
        wt[i][j] = 16'($urandom_range(1, 65535));
      end
  endtask
  task automatic run_recall(input logic [4:0] k, output int lat, output int nreads, output bit ok);
    lat = 0;
    nreads = 0;
    ok = 1'b1;
    @(negedge clk);
    bus.recall_start = 1'b1;
    bus.key_class = k;
    @(negedge clk);
    bus.recall_start = 1'b0;
    bus.key_class = 5'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (bus.conn_rd_en) begin
        if (bus.conn_rd_resp != nreads[3:0] || bus.conn_rd_key != k[3:0] || c != nreads + 1) ok = 1'b0;
        nreads++;
      end
      if (!bus.recall_busy) ok = 1'b0;
      if (bus.recall_done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.recall_start = 1'b0;
    bus.key_class = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.recall_busy, bus.recall_done, bus.recall_found, bus.response_class, bus.response_weight,
         bus.conn_rd_en, bus.conn_rd_key, bus.conn_rd_resp} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b found=%b class=%0d weight=%0h rd_en=%b required all 0",
               bus.recall_busy, bus.recall_done, bus.recall_found, bus.response_class, bus.response_weight, bus.conn_rd_en);
    end
    rst = 1'b0;
  endtask
  task automatic test_single;
    int lat, n;
    bit ok;
    clear_mem();
    pres[3][5] = 1'b1;
    wt[3][5] = 16'd7;
    run_recall(5'd3, lat, n, ok);
    vectors++;
    if (lat !== 18) begin
      miscompares++;
      $display("FAIL single_latency: got %0d required 18", lat);
    end
    vectors++;
    if (n !== 16 || !ok) begin
      miscompares++;
      $display("FAIL single_reads: got %0d reads order_ok=%b required 16 in order", n, ok);
    end
    vectors++;
    if ({bus.recall_found, bus.response_class, bus.response_weight} !== {1'b1, 4'd5, 16'd7}) begin
      miscompares++;
      $display("FAIL single_result: got found=%b class=%0d weight=%0d required 1/5/7",
               bus.recall_found, bus.response_class, bus.response_weight);
    end
    @(negedge clk);
    vectors++;
    if ({bus.recall_done, bus.recall_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_after_done: got done=%b busy=%b required 0/0", bus.recall_done, bus.recall_busy);
    end
  endtask
  task automatic test_tie;
    int lat, n;
    bit ok;
    clear_mem();
    pres[2][1] = 1'b1;
    wt[2][1] = 16'd4;
    pres[2][9] = 1'b1;
    wt[2][9] = 16'd9;
    pres[2][14] = 1'b1;
    wt[2][14] = 16'd9;
    run_recall(5'd2, lat, n, ok);
    vectors++;
    if ({bus.recall_found, bus.response_class, bus.response_weight} !== {1'b1, 4'd9, 16'd9} || lat !== 18) begin
      miscompares++;
      $display("FAIL tie_lowest: got found=%b class=%0d weight=%0d lat=%0d required 1/9/9 lat 18",
               bus.recall_found, bus.response_class, bus.response_weight, lat);
    end
  endtask
  task automatic test_absent;
    int lat, n;
    bit ok;
    clear_mem();
    pres[1][0] = 1'b1;
    run_recall(5'd0, lat, n, ok);
    vectors++;
    if ({bus.recall_found, bus.response_class, bus.response_weight} !== 21'd0 || lat !== 18) begin
      miscompares++;
      $display("FAIL absent_row: got found=%b class=%0d weight=%0h lat=%0d required 0/0/0 lat 18",
               bus.recall_found, bus.response_class, bus.response_weight, lat);
    end
  endtask
  task automatic test_full_width;
    int lat, n;
    bit ok;
    clear_mem();
    pres[7][0] = 1'b1;
    wt[7][0] = 16'hFFFE;
    pres[7][15] = 1'b1;
    wt[7][15] = 16'hFFFF;
    run_recall(5'd7, lat, n, ok);
    vectors++;
    if ({bus.recall_found, bus.response_class, bus.response_weight} !== {1'b1, 4'd15, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL full_width: got found=%b class=%0d weight=%0h required 1/15/ffff",
               bus.recall_found, bus.response_class, bus.response_weight);
    end
  endtask
  task automatic test_abort;
    int lat, n;
    bit ok, bad;
    logic f;
    logic [3:0] c;
    logic [15:0] w;
    @(negedge clk);
    bus.recall_start = 1'b1;
    bus.key_class = 5'd7;
    @(negedge clk);
    bus.recall_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.recall_start = 1'b1;
    @(negedge clk);
    bus.recall_start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({bus.conn_rd_en, bus.conn_rd_resp, bus.recall_busy} !== {1'b1, 4'd9, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_midscan: got rd_en=%b col=%0d busy=%b required 1/9/1",
               bus.conn_rd_en, bus.conn_rd_resp, bus.recall_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({bus.recall_busy, bus.recall_done, bus.recall_found, bus.response_class, bus.response_weight,
         bus.conn_rd_en, bus.conn_rd_key, bus.conn_rd_resp} !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_reset_outputs: got busy=%b rd_en=%b found=%b class=%0d weight=%0h required all 0",
               bus.recall_busy, bus.conn_rd_en, bus.recall_found, bus.response_class, bus.response_weight);
    end
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.recall_done || bus.conn_rd_en || bus.recall_busy) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: got activity after reset=%b required 0", bad);
    end
    model(5'd7, f, c, w);
    run_recall(5'd7, lat, n, ok);
    vectors++;
    if ({bus.recall_found, bus.response_class, bus.response_weight} !== {f, c, w} || lat !== 18 || n !== 16 || !ok) begin
      miscompares++;
      $display("FAIL abort_restart: got %b/%0d/%0h lat=%0d reads=%0d required %b/%0d/%0h lat 18 reads 16",
               bus.recall_found, bus.response_class, bus.response_weight, lat, n, f, c, w);
    end
  endtask
  task automatic test_out_of_range;
    int lat, n;
    bit ok;
    run_recall(5'd16, lat, n, ok);
    vectors++;
    if (lat !== 1 || n !== 0 || !ok) begin
      miscompares++;
      $display("FAIL oor_timing: got lat=%0d reads=%0d busy_ok=%b required lat 1 reads 0", lat, n, ok);
    end
    vectors++;
    if ({bus.recall_found, bus.response_class, bus.response_weight} !== 21'd0) begin
      miscompares++;
      $display("FAIL oor_result: got found=%b class=%0d weight=%0h required 0/0/0",
               bus.recall_found, bus.response_class, bus.response_weight);
    end
    run_recall(5'd31, lat, n, ok);
    vectors++;
    if (lat !== 1 || n !== 0 || bus.recall_found !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_max_key: got lat=%0d reads=%0d found=%b required 1/0/0", lat, n, bus.recall_found);
    end
  endtask
  task automatic test_back_to_back;
    logic [4:0] k1, k2;
    logic f1, f2;
    logic [3:0] c1, c2;
    logic [15:0] w1, w2;
    logic [20:0] r1, r2;
    int d1, d2;
    logic busy19;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        pres[i][j] = ($urandom_range(0, 2) == 0);
        wt[i][j] = 16'($urandom);
      end
    k1 = 5'($urandom_range(0, 15));
    k2 = 5'((k1 + 5) % 16);
    model(k1, f1, c1, w1);
    model(k2, f2, c2, w2);
    d1 = 0;
    d2 = 0;
    busy19 = 1'b1;
    r1 = '0;
    r2 = '0;
    @(negedge clk);
    bus.recall_start = 1'b1;
    bus.key_class = k1;
    @(negedge clk);
    bus.key_class = k2;
    for (int c = 1; c <= 60; c++) begin
      if (c == 19) busy19 = bus.recall_busy;
      if (bus.recall_done && d1 == 0) begin
        d1 = c;
        r1 = {bus.recall_found, bus.response_class, bus.response_weight};
      end else if (bus.recall_done) begin
        d2 = c;
        r2 = {bus.recall_found, bus.response_class, bus.response_weight};
        break;
      end
      @(negedge clk);
    end
    bus.recall_start = 1'b0;
    vectors++;
    if (d1 !== 18 || d2 !== 37 || busy19 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_timing: got done at %0d and %0d busy@19=%b required 18 and 37 busy 0", d1, d2, busy19);
    end
    vectors++;
    if (r1 !== {f1, c1, w1} || r2 !== {f2, c2, w2}) begin
      miscompares++;
      $display("FAIL b2b_results: got %h %h required %h %h", r1, r2, {f1, c1, w1}, {f2, c2, w2});
    end
  endtask
  task automatic test_random;
    int lat, n;
    bit ok;
    logic [4:0] k;
    logic f;
    logic [3:0] c;
    logic [15:0] w;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) begin
          pres[i][j] = ($urandom_range(0, 3) == 0);
          wt[i][j] = (it % 2 == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
        end
      k = 5'($urandom_range(0, 19));
      model(k, f, c, w);
      run_recall(k, lat, n, ok);
      vectors++;
      if (lat !== ((k < 5'd16) ? 18 : 1) || n !== ((k < 5'd16) ? 16 : 0) || !ok) begin
        miscompares++;
        $display("FAIL random_timing[%0d]: key=%0d got lat=%0d reads=%0d ok=%b", it, k, lat, n, ok);
      end
      vectors++;
      if ({bus.recall_found, bus.response_class, bus.response_weight} !== {f, c, w}) begin
        miscompares++;
        $display("FAIL random_result[%0d]: key=%0d got %b/%0d/%0h required %b/%0d/%0h", it, k,
                 bus.recall_found, bus.response_class, bus.response_weight, f, c, w);
      end
    end
  endtask
  initial begin
    vectors = 0;
    miscompares = 0;
    clear_mem();
    test_reset();
    test_single();
    test_tie();
    test_absent();
    test_full_width();
    test_abort();
    test_out_of_range();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/assoc_recall.md
# assoc_recall

Associative recall engine for the GAM associative layer, and the read-side counterpart of associative learning. Given a key class, it scans that key's row of the associative-layer connection memory and returns the response class with the largest connection weight. The memory layer uses the returned class to select the recalled prototype. It is the sole reader of the connection array during recall and shares that array with the learning path, which writes it.

## Interface
Parameters:
- NUM_CLASSES, 16, number of classes; the connection array is NUM_CLASSES x NUM_CLASSES.
- CLASS_W, $clog2(NUM_CLASSES) (4), width of class indices.
- WEIGHT_W, 16, width of connection weights.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- recall_start  in  1  request a recall; sampled only in IDLE.
- key_class  in  CLASS_W+1  key class to recall from; latched when recall_start is accepted. The extra MSB allows out-of-range detection.
- recall_busy  out  1  high from the cycle after acceptance through the DONE cycle inclusive.
- recall_done  out  1  one-cycle pulse when the result is valid.
- recall_found  out  1  at least one present connection existed for the key.
- response_class  out  CLASS_W  winning response class; 0 when not found.
- response_weight  out  WEIGHT_W  weight of the winning connection; 0 when not found.
- conn_rd_en  out  1  connection-memory read strobe.
- conn_rd_key  out  CLASS_W  read row, equal to the latched key.
- conn_rd_resp  out  CLASS_W  read column (response class).
- conn_rd_presence  in  1  connection_presence bit. Valid exactly 1 cycle after conn_rd_en.
- conn_rd_weight  in  WEIGHT_W  connection weight. Valid with conn_rd_presence.

## Operation
- The FSM has four states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - If recall_start=1 and key_class < NUM_CLASSES, latch the key, clear the candidate (found=0, best=0, class=0), set the column counter to 0, and go to SCAN.
  - If recall_start=1 and key_class >= NUM_CLASSES, clear the candidate and go directly to DONE (found=0, no reads).
  - Otherwise stay in IDLE.
- SCAN:
  - Assert conn_rd_en with conn_rd_resp = counter, then increment the counter.
  - Evaluate the data returned for the previous column.
  - After column NUM_CLASSES-1 is issued, go to DRAIN.
- DRAIN: conn_rd_en=0; evaluate the data for the last column; go to DONE.
- DONE: pulse recall_done=1; go to IDLE.
- Evaluation rule:
  - A column becomes the candidate when presence=1 and (found=0 or weight > best weight).
  - The comparison is strict unsigned, so ties keep the lowest response index.
  - A present connection with weight 0 is still a valid candidate.
  - Absent connections are ignored regardless of their weight value.
- The counter is CLASS_W+1 bits wide so it never wraps within a scan.
- recall_start while busy is ignored and is not queued.
- response_class, response_weight and recall_found update only in the DONE cycle and hold until the next DONE.
- Reset at any point, including mid-scan:
  - FSM goes to IDLE and the candidate is cleared.
  - All outputs go to 0 on the next edge.
  - No done pulse is generated for the aborted recall.
  - Read data returned after reset is ignored.

## Timing
- Reset values: recall_busy=0, recall_done=0, recall_found=0, response_class=0, response_weight=0, conn_rd_en=0, conn_rd_key=0, conn_rd_resp=0.
- Cycle sequence, with recall_start sampled high at edge T:
  - conn_rd_en is high at edges T+1..T+N (N = NUM_CLASSES), with column = edge - (T+1).
  - Data arrives at T+2..T+N+1.
  - DRAIN occurs at T+N+1.
  - recall_done and the outputs appear at T+N+2.
- Latency is N+2 cycles (18 for N=16). Back-to-back throughput is one recall per N+3 cycles.
- Out-of-range key: recall_done at T+1, with no conn_rd_en.
- recall_busy is high T+1..T+N+2 (T+1 only for an out-of-range key). It is low in the cycle after done, so a new start is accepted the cycle after DONE.
- conn_rd_key is stable for the whole scan.

## Test plan
- Key 3, with presence only at column 5 (weight 7) -> done at T+18, found=1, class=5, weight=7; exactly 16 reads, columns 0..15 in order.
- Key 2, with columns 1/9/14 present at weights 4/9/9 -> class=9, weight=9 (tie keeps the lower index).
- Key 0, with no present connections but nonzero weight data on absent columns -> found=0, class=0, weight=0.
- key_class=16 (N=16) -> done at T+1, found=0, no conn_rd_en ever asserted.
- Start at T; pulse start again at T+5; assert rst at T+10 -> the second start is ignored. After reset: rd_en=0 from T+11, no done pulse, busy=0. A new start then completes normally.
- Present weight 0xFFFF at column 15 versus 0xFFFE at column 0 -> class=15; confirms full-width unsigned comparison.
